median_share_arbiter: RTL and testbench



---
 rtl/median_share_arbiter_if.sv | 22 ++
 rtl/median_share_arbiter.sv | 125 ++++++++++++
 tb/tb_median_share_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/median_share_arbiter_if.sv
// rtl/median_share_arbiter_if.sv - requester-side request/response bus of the shared median arbiter
interface median_share_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_word0;
    logic [32*NREQ-1:0] req_word1;
    logic [32*NREQ-1:0] req_word2;
    logic [NREQ-1:0]    resp_valid;
    logic [31:0]        resp_data;

    modport master (
        output req_valid, req_word0, req_word1, req_word2,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_word0, req_word1, req_word2,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/median_share_arbiter.sv
// rtl/median_share_arbiter.sv - round-robin sharing of one pipelined median unit among NREQ requesters
module median_share_arbiter #(
    parameter int NREQ       = 3,
    parameter int MED_LAT    = 2,
    parameter int RST_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    median_share_arbiter_if.slave        bus,
    output logic                         busy,
    output logic [31:0]                  issued_count,
    output logic                         med_rst_n,
    output logic [31:0]                  med_word0,
    output logic [31:0]                  med_word1,
    output logic [31:0]                  med_word2,
    input  logic [31:0]                  med_median_word
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic {MED_RST, RUN} state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              rst_cnt_q, rst_cnt_d;
    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [31:0]                issued_q, issued_d;
    logic [MED_LAT-1:0]         tag_v_q, tag_v_d;
    logic [MED_LAT-1:0][PW-1:0] tag_id_q, tag_id_d;

    logic          run;
    logic          grant_found;
    logic [PW-1:0] grant_idx;
    logic [PW:0]   cand;
    logic          xfer;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        if (state_q == MED_RST) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == CW'(RST_CYCLES - 1)) begin
                state_d = RUN;
            end
        end
    end

    // Gating with rst keeps every combinational output at its reset value while rst is high.
    assign run       = (state_q == RUN) && !rst;
    assign med_rst_n = run;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    assign xfer = run && grant_found;

    always_comb begin
        bus.req_ready = '0;
        med_word0     = '0;
        med_word1     = '0;
        med_word2     = '0;
        if (xfer) begin
            bus.req_ready[grant_idx] = 1'b1;
            med_word0 = bus.req_word0[32*int'(grant_idx) +: 32];
            med_word1 = bus.req_word1[32*int'(grant_idx) +: 32];
            med_word2 = bus.req_word2[32*int'(grant_idx) +: 32];
        end
    end

    always_comb begin
        tag_v_d[0]  = xfer;
        tag_id_d[0] = grant_idx;
        for (int i = 1; i < MED_LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        issued_d = issued_q + 32'(xfer);
    end

    always_comb begin
        bus.resp_valid = '0;
        bus.resp_data  = '0;
        if (!rst && tag_v_q[MED_LAT-1]) begin
            bus.resp_valid[tag_id_q[MED_LAT-1]] = 1'b1;
            bus.resp_data = med_median_word;
        end
    end

    assign busy         = !rst && (|tag_v_q);
    assign issued_count = issued_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MED_RST;
            rst_cnt_q <= '0;
            rr_ptr_q  <= '0;
            issued_q  <= '0;
            tag_v_q   <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            issued_q  <= issued_d;
            tag_v_q   <= tag_v_d;
            tag_id_q  <= tag_id_d;
        end
    end
endmodule

// File: tb/tb_median_share_arbiter.sv
// tb/tb_median_share_arbiter.sv - scoreboard bench for median_share_arbiter with a behavioural median unit
module tb_median_share_arbiter;
    localparam int NREQ       = 3;
    localparam int MED_LAT    = 2;
    localparam int RST_CYCLES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median_share_arbiter_if #(.NREQ(NREQ)) bus ();
    logic        busy;
    logic [31:0] issued_count;
    logic        med_rst_n;
    logic [31:0] med_word0, med_word1, med_word2, med_median_word;

    median_share_arbiter #(.NREQ(NREQ), .MED_LAT(MED_LAT), .RST_CYCLES(RST_CYCLES)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .busy            (busy),
        .issued_count    (issued_count),
        .med_rst_n       (med_rst_n),
        .med_word0       (med_word0),
        .med_word1       (med_word1),
        .med_word2       (med_word2),
        .med_median_word (med_median_word)
    );

    function automatic logic [31:0] med3(logic [31:0] a, logic [31:0] b, logic [31:0] c);
        if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
        if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
        return c;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int id);
        logic [NREQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Median unit: result appears MED_LAT cycles after its words are presented.
    logic [31:0] med_pipe [MED_LAT];
    always @(posedge clk) begin
        med_pipe[0] <= med3(med_word0, med_word1, med_word2);
        for (int i = 1; i < MED_LAT; i++) med_pipe[i] <= med_pipe[i-1];
    end
    assign med_median_word = med_pipe[MED_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   accepts[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [NREQ-1:0] rv;
    logic [31:0]     w0 [NREQ];
    logic [31:0]     w1 [NREQ];
    logic [31:0]     w2 [NREQ];
    int              since = 0;
    int              m_rr = 0;
    logic [31:0]     m_issued = '0;

    task automatic set_words(int i, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        w0[i] = a;
        w1[i] = b;
        w2[i] = c;
    endtask

    task automatic rand_words();
        for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 1) == 0)
                set_words(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            else
                set_words(i, $urandom, $urandom, $urandom);
        end
    endtask

    // Called just after a rising edge: applies inputs, checks against the model mid-cycle.
    task automatic do_cycle();
        bit exp_run, exp_busy;
        int g, idx;
        bus.req_valid = rv;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_word0[i*32 +: 32] = w0[i];
            bus.req_word1[i*32 +: 32] = w1[i];
            bus.req_word2[i*32 +: 32] = w2[i];
        end
        @(negedge clk);
        exp_run = !rst && (since >= RST_CYCLES);
        g = -1;
        if (exp_run) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (g < 0 && rv[idx]) g = idx;
            end
        end
        exp_busy = 1'b0;
        foreach (accepts[j])
            if (!rst && accepts[j] + 1 <= cyc && cyc <= accepts[j] + MED_LAT) exp_busy = 1'b1;
        check("req_ready", bus.req_ready, (g >= 0) ? onehot(g) : '0);
        check("med_rst_n", med_rst_n, exp_run);
        check("busy", busy, exp_busy);
        check("issued_count", issued_count, m_issued);
        if (g >= 0) begin
            check("med_word0", med_word0, w0[g]);
            check("med_word1", med_word1, w1[g]);
            check("med_word2", med_word2, w2[g]);
            sb.push_back('{id: g, data: med3(w0[g], w1[g], w2[g]), due: cyc + MED_LAT});
            accepts.push_back(cyc);
            m_rr = (g + 1) % NREQ;
            m_issued++;
        end else begin
            check("med_word0_idle", med_word0, 32'd0);
        end
        while (accepts.size() > 0 && accepts[0] + MED_LAT < cyc) void'(accepts.pop_front());
        if (rst) begin
            sb.delete();
            accepts.delete();
            m_rr = 0;
            m_issued = '0;
            since = 0;
        end else begin
            since++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("resp_in_rst", bus.resp_valid, '0);
            end else if (bus.resp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", bus.resp_valid, '0);
                end else begin
                    e = sb.pop_front();
                    check("resp_valid", bus.resp_valid, onehot(e.id));
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_time", cyc, e.due);
                end
            end else begin
                check("resp_data_idle", bus.resp_data, 32'd0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    check("resp_missing", bus.resp_valid, onehot(e.id));
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        rv  = '0;
        for (int i = 0; i < NREQ; i++) set_words(i, 0, 0, 0);
        bus.req_valid = '0;
        bus.req_word0 = '0;
        bus.req_word1 = '0;
        bus.req_word2 = '0;
        @(posedge clk);
        #1;
        repeat (3) do_cycle();
        rst = 1'b0;
        rv  = '1;
        repeat (RST_CYCLES) do_cycle();
        rv = '0;
        do_cycle();

        rv = 3'b010;
        set_words(1, 9, 3, 5);
        do_cycle();
        rv = '0;
        repeat (3) do_cycle();

        rv = '1;
        repeat (6) begin
            rand_words();
            do_cycle();
        end
        rv = 3'b101;
        repeat (3) begin
            rand_words();
            do_cycle();
        end

        rv = 3'b001;
        set_words(0, 1, 2, 3);
        do_cycle();
        set_words(0, 10, 30, 20);
        do_cycle();
        set_words(0, 7, 7, 4);
        do_cycle();
        rv = '0;
        repeat (3) do_cycle();

        repeat (300) begin
            rv = NREQ'($urandom);
            rand_words();
            do_cycle();
        end

        rv = '1;
        repeat (2) begin
            rand_words();
            do_cycle();
        end
        rst = 1'b1;
        repeat (2) do_cycle();
        rst = 1'b0;
        repeat (60) begin
            rv = NREQ'($urandom);
            rand_words();
            do_cycle();
        end

        rv = '0;
        repeat (MED_LAT + 3) do_cycle();
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
